// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one native-memory-interface slave port between
// NUM_MST masters. One transaction is in flight at a time and the grant is held
// until the slave completes. A watchdog terminates the transaction if the
// slave stays silent too long, returning TO_RDATA to the stalled master.
module nmi_rr_arbiter #(
  parameter int unsigned NUM_MST  = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] TO_RDATA = 32'hFFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,

  // Master side
  input  logic [NUM_MST-1:0]    m_valid_i,
  input  logic [NUM_MST*32-1:0] m_addr_i,
  input  logic [NUM_MST*32-1:0] m_wdata_i,
  input  logic [NUM_MST*4-1:0]  m_wstrb_i,
  output logic [NUM_MST-1:0]    m_ready_o,
  output logic [31:0]           m_rdata_o,

  // Slave side
  output logic                  s_valid_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wdata_o,
  output logic [3:0]            s_wstrb_o,
  input  logic                  s_ready_i,
  input  logic [31:0]           s_rdata_i,

  // Status
  output logic [NUM_MST-1:0]    grant_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned IdxW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MST - 1);
  localparam logic [15:0]     ToCnt   = 16'(TIMEOUT);
  localparam bit              WdogEn  = (TIMEOUT != 0);

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] g_q, g_d;
  logic [IdxW-1:0] lg_q, lg_d;
  logic [15:0]     cnt_q, cnt_d;

  // Per-master request fields unpacked for indexing by the grant index.
  logic [31:0] addr_arr  [NUM_MST];
  logic [31:0] wdata_arr [NUM_MST];
  logic [3:0]  wstrb_arr [NUM_MST];

  logic              arb_hit;
  logic [IdxW-1:0]   arb_idx;
  logic [NUM_MST-1:0] g_oh;
  logic              xfer;
  logic              sel_valid;
  logic              abort;
  logic              done;
  logic              to_hit;

  // Split flattened master buses into per-master fields.
  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      addr_arr[i]  = m_addr_i[i*32 +: 32];
      wdata_arr[i] = m_wdata_i[i*32 +: 32];
      wstrb_arr[i] = m_wstrb_i[i*4 +: 4];
    end
  end

  // Circular scan starting just after the last-granted master, so the master
  // that completed most recently has the lowest priority.
  always_comb begin
    int unsigned cand;
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_MST; i++) begin
      cand = (32'(lg_q) + i) % NUM_MST;
      if (!arb_hit && m_valid_i[cand[IdxW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[IdxW-1:0];
      end
    end
  end

  // One-hot form of the current grant index.
  always_comb begin
    g_oh      = '0;
    g_oh[g_q] = 1'b1;
  end

  // Transfer-cycle event decode; abort outranks completion, completion
  // outranks the watchdog.
  always_comb begin
    xfer      = (state_q == StXfer);
    sel_valid = m_valid_i[g_q];
    abort     = xfer && !sel_valid;
    done      = xfer && sel_valid && s_ready_i;
    to_hit    = WdogEn && xfer && sel_valid && !s_ready_i && (cnt_q == ToCnt);
  end

  // Slave request mux and master response outputs.
  always_comb begin
    s_valid_o = xfer && sel_valid && !to_hit;
    s_addr_o  = xfer ? addr_arr[g_q]  : 32'h0;
    s_wdata_o = xfer ? wdata_arr[g_q] : 32'h0;
    s_wstrb_o = xfer ? wstrb_arr[g_q] : 4'h0;

    m_ready_o = (done || to_hit) ? g_oh : '0;
    if (done) begin
      m_rdata_o = s_rdata_i;
    end else if (to_hit) begin
      m_rdata_o = TO_RDATA;
    end else begin
      m_rdata_o = 32'h0;
    end
    timeout_o = to_hit;

    grant_o = xfer ? g_oh : '0;
    busy_o  = xfer;
  end

  // Next-state logic: arbitrate in IDLE, track the slave wait in XFER.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    lg_d    = lg_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (arb_hit) begin
          state_d = StXfer;
          g_d     = arb_idx;
          cnt_d   = 16'h0;
        end
      end
      StXfer: begin
        if (abort || done || to_hit) begin
          state_d = StIdle;
          lg_d    = g_q;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; lg resets to the last index so master 0 wins first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      g_q     <= '0;
      lg_q    <= LastIdx;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Directed testbench for nmi_rr_arbiter (2 masters, 4-cycle watchdog).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Completions are checked by a scoreboard monitor.
module tb_nmi_rr_arbiter;

  localparam int unsigned NM = 2;

  logic          clk;
  logic          rst_n;
  logic [NM-1:0] m_valid;
  logic [63:0]   m_addr;
  logic [63:0]   m_wdata;
  logic [7:0]    m_wstrb;
  logic [NM-1:0] m_ready;
  logic [31:0]   m_rdata;
  logic          s_valid;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_ready;
  logic [31:0]   s_rdata;
  logic [NM-1:0] grant;
  logic          busy;
  logic          timeout;

  typedef struct packed {
    logic [1:0]  rdy;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  nmi_rr_arbiter #(
    .NUM_MST (2),
    .TIMEOUT (4),
    .TO_RDATA(32'hFFFF_FFFF)
  ) u_dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .m_valid_i(m_valid),
    .m_addr_i (m_addr),
    .m_wdata_i(m_wdata),
    .m_wstrb_i(m_wstrb),
    .m_ready_o(m_ready),
    .m_rdata_o(m_rdata),
    .s_valid_o(s_valid),
    .s_addr_o (s_addr),
    .s_wdata_o(s_wdata),
    .s_wstrb_o(s_wstrb),
    .s_ready_i(s_ready),
    .s_rdata_i(s_rdata),
    .grant_o  (grant),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_time_limit: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard monitor: every completion must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && ((m_ready != 0) || timeout)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_completion: got ready=%b rdata=%h to=%b, required none",
                 m_ready, m_rdata, timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_ready, m_rdata, timeout} !== mon_e) begin
          n_fail++;
          $display("FAIL completion: got ready=%b rdata=%h to=%b, required ready=%b rdata=%h to=%b",
                   m_ready, m_rdata, timeout, mon_e.rdy, mon_e.rdata, mon_e.to);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic set_m(input int idx, input logic v, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    m_valid[idx]          = v;
    m_addr[idx*32 +: 32]  = a;
    m_wdata[idx*32 +: 32] = wd;
    m_wstrb[idx*4 +: 4]   = ws;
  endtask

  task automatic clr_all();
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  logic [1:0] cont_g [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

  initial begin
    rst_n = 1'b0;
    clr_all();
    cyc();
    cyc();
    mid();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single read with a two-cycle slave wait.
    set_m(0, 1'b1, 32'h0300_0000, 32'h0, 4'h0);
    mid();
    chk("rd_pre_grant", 32'(grant), 32'h0);
    cyc();
    mid();
    chk("rd_s_valid", 32'(s_valid), 32'h1);
    chk("rd_s_addr", s_addr, 32'h0300_0000);
    chk("rd_grant", 32'(grant), 32'h1);
    cyc();
    mid();
    chk("rd_wait_ready", 32'(m_ready), 32'h0);
    cyc();
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_0001;
    exp_q.push_back('{rdy: 2'b01, rdata: 32'hCAFE_0001, to: 1'b0});
    mid();
    cyc();
    clr_all();
    mid();
    chk("rd_post_grant", 32'(grant), 32'h0);
    chk("rd_post_ready", 32'(m_ready), 32'h0);

    // Write routed from master 1.
    cyc();
    set_m(1, 1'b1, 32'h0400_0010, 32'h1234_5678, 4'b0011);
    cyc();
    mid();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_s_valid", 32'(s_valid), 32'h1);
    chk("wr_s_addr", s_addr, 32'h0400_0010);
    chk("wr_s_wdata", s_wdata, 32'h1234_5678);
    chk("wr_s_wstrb", 32'(s_wstrb), 32'h3);
    cyc();
    s_ready = 1'b1;
    s_rdata = 32'h0000_0BAD;
    exp_q.push_back('{rdy: 2'b10, rdata: 32'h0000_0BAD, to: 1'b0});
    mid();
    chk("wr_s_wdata_done", s_wdata, 32'h1234_5678);
    cyc();
    clr_all();
    mid();
    chk("wr_post_grant", 32'(grant), 32'h0);

    // Contention with a zero-wait slave: 0,1,0,1 with an idle cycle between.
    cyc();
    set_m(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    set_m(1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
    s_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      s_rdata = 32'hA000_0000 + 32'(k);
      if (cont_g[k] != 2'b00) begin
        exp_q.push_back('{rdy: cont_g[k], rdata: 32'hA000_0000 + 32'(k), to: 1'b0});
      end
      if (k == 7) begin
        clr_all();
      end
      mid();
      chk($sformatf("cont_grant_%0d", k), 32'(grant), 32'(cont_g[k]));
      chk($sformatf("cont_busy_%0d", k), 32'(busy), 32'(cont_g[k] != 2'b00));
    end
    cyc();
    mid();
    chk("cont_end_grant", 32'(grant), 32'h0);

    // Watchdog expiry on master 0, then master 1 with ready exactly at expiry.
    cyc();
    set_m(0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
    set_m(1, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 5) begin
        exp_q.push_back('{rdy: 2'b01, rdata: 32'hFFFF_FFFF, to: 1'b1});
      end
      mid();
      chk($sformatf("to_grant_%0d", k), 32'(grant), 32'h1);
      chk($sformatf("to_s_valid_%0d", k), 32'(s_valid), 32'(k < 5));
    end
    cyc();
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    chk("to_idle_grant", 32'(grant), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 5) begin
        s_ready = 1'b1;
        s_rdata = 32'h5A5A_5A5A;
        exp_q.push_back('{rdy: 2'b10, rdata: 32'h5A5A_5A5A, to: 1'b0});
      end
      mid();
      chk($sformatf("to2_grant_%0d", k), 32'(grant), 32'h2);
      chk($sformatf("to2_s_valid_%0d", k), 32'(s_valid), 32'h1);
    end
    cyc();
    clr_all();
    mid();
    chk("to2_post_busy", 32'(busy), 32'h0);

    // Abort: master 0 drops valid in its second XFER cycle.
    cyc();
    set_m(0, 1'b1, 32'h0000_0500, 32'h0, 4'h0);
    set_m(1, 1'b1, 32'h0000_0600, 32'h0, 4'h0);
    cyc();
    mid();
    chk("ab_grant_1", 32'(grant), 32'h1);
    chk("ab_s_valid_1", 32'(s_valid), 32'h1);
    cyc();
    set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_0002;
    mid();
    chk("ab_s_valid_2", 32'(s_valid), 32'h0);
    chk("ab_m_ready_2", 32'(m_ready), 32'h0);
    cyc();
    s_ready = 1'b0;
    mid();
    chk("ab_idle_grant", 32'(grant), 32'h0);
    chk("ab_idle_busy", 32'(busy), 32'h0);
    cyc();
    s_ready = 1'b1;
    s_rdata = 32'hABCD_0004;
    exp_q.push_back('{rdy: 2'b10, rdata: 32'hABCD_0004, to: 1'b0});
    mid();
    chk("ab_next_grant", 32'(grant), 32'h2);
    cyc();
    clr_all();
    mid();

    // Reset in the middle of a master 1 transfer.
    cyc();
    set_m(1, 1'b1, 32'h0000_0700, 32'h0, 4'h0);
    cyc();
    mid();
    chk("rm_pre_grant", 32'(grant), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_grant", 32'(grant), 32'h0);
    chk("rm_busy", 32'(busy), 32'h0);
    chk("rm_s_valid", 32'(s_valid), 32'h0);
    chk("rm_s_addr", s_addr, 32'h0);
    chk("rm_m_ready", 32'(m_ready), 32'h0);
    cyc();
    rst_n = 1'b1;
    set_m(0, 1'b1, 32'h0000_0800, 32'h0, 4'h0);
    cyc();
    mid();
    chk("rm_first_grant", 32'(grant), 32'h1);
    cyc();
    s_ready = 1'b1;
    s_rdata = 32'h7777_0006;
    exp_q.push_back('{rdy: 2'b01, rdata: 32'h7777_0006, to: 1'b0});
    mid();
    cyc();
    clr_all();
    mid();
    chk("rm_post_grant", 32'(grant), 32'h0);

    cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nmi_rr_arbiter.md
# nmi_rr_arbiter

Round-robin arbiter sharing one native-memory-interface (valid/ready/addr/wdata/wstrb/rdata) slave port between NUM_MST masters, e.g. the CPU core and a DMA engine contending for the PSRAM or a single peripheral window on `u_bus`. It sequences one transaction at a time and holds the grant until the slave completes. A watchdog terminates hung transactions so that a dead slave cannot lock up the SoC.

## Interface
Parameters:
- NUM_MST, 2, number of masters (2..8)
- TIMEOUT, 255, slave wait limit in cycles (1..65535); 0 disables the watchdog
- TO_RDATA, 32'hFFFF_FFFF, read data returned on timeout

Ports:
- clk_i  in  1  system clock; single clock domain
- rst_n_i  in  1  asynchronous active-low reset
- m_valid_i  in  NUM_MST  per-master request
- m_addr_i  in  NUM_MST×32  per-master address
- m_wdata_i  in  NUM_MST×32  per-master write data
- m_wstrb_i  in  NUM_MST×4  per-master byte strobes; 0 means read
- m_ready_o  out  NUM_MST  per-master completion, one-hot, 1-cycle pulse
- m_rdata_o  out  32  read data shared by all masters; valid only with m_ready_o
- s_valid_o  out  1  slave request
- s_addr_o  out  32  slave address
- s_wdata_o  out  32  slave write data
- s_wstrb_o  out  4  slave byte strobes
- s_ready_i  in  1  slave completion
- s_rdata_i  in  32  slave read data
- grant_o  out  NUM_MST  one-hot current owner; 0 when idle
- busy_o  out  1  high while in XFER
- timeout_o  out  1  1-cycle pulse on watchdog termination

## Operation
- States: IDLE and XFER. Registers: state, grant index g, last-granted index lg, wait counter (16 bit).
- IDLE: if any m_valid_i is set, select the first requesting index scanning circularly from lg+1. Register g, go to XFER, clear the counter. If no request is pending, stay in IDLE.
- XFER: s_valid_o=1. s_addr_o/s_wdata_o/s_wstrb_o are combinationally muxed from master g. Masters hold their inputs stable until ready.
- Completion: when s_ready_i=1 in XFER, m_ready_o[g]=1 and m_rdata_o=s_rdata_i in the same cycle. Next state is IDLE and lg<=g.
- Watchdog (TIMEOUT≠0): the counter increments on each XFER cycle with s_ready_i=0. In the cycle where the counter equals TIMEOUT and s_ready_i=0:
  - s_valid_o=0
  - m_ready_o[g]=1 and m_rdata_o=TO_RDATA
  - timeout_o=1
  - next state IDLE and lg<=g
- Simultaneous s_ready_i and watchdog expiry: the slave wins. Normal completion applies and timeout_o stays 0.
- Abort: if m_valid_i[g] drops in XFER before completion (protocol violation), s_valid_o drops in that same cycle. No m_ready_o is issued. Next state is IDLE and lg<=g. A late s_ready_i in that cycle is ignored.
- When not in XFER, s_valid_o=0 and s_addr_o/s_wdata_o/s_wstrb_o=0. m_ready_o=0 and m_rdata_o=0 except in the completion or timeout cycle.
- Fairness: a master that just completed has the lowest priority in the next arbitration, so any other waiting master is served within NUM_MST-1 transactions.

## Timing
- Reset values: state=IDLE, g=0, lg=NUM_MST-1 (master 0 wins the first arbitration), counter=0. All outputs are 0.
- Reset mid-transfer: outputs are cleared immediately (asynchronously). The transaction is lost and no m_ready_o is issued.
- Request latency: m_valid_i rises before edge N; s_valid_o and grant_o are high from edge N.
- Zero-wait slave: m_ready_o is asserted in the first XFER cycle, so one transaction takes 2 cycles (XFER + IDLE).
- Back-to-back transactions: there is always exactly one IDLE cycle between consecutive grants, with grant_o=0 and busy_o=0 in that cycle.
- Timeout: with TIMEOUT=T, m_ready_o is asserted in XFER cycle T+1, counting the first XFER cycle as 1.
- m_ready_o, timeout_o and m_rdata_o are combinational from state and s_ready_i. grant_o and busy_o are registered.

## Test plan
- Single read: master 0 requests addr 32'h0300_0000 with wstrb=0, and the slave returns ready with rdata 32'hCAFE_0001 two cycles after s_valid_o. Required: s_addr_o matches, m_ready_o=2'b01 for exactly one cycle with m_rdata_o=32'hCAFE_0001, grant_o=0 on the following cycle.
- Contention: both masters hold valid continuously for 4 transactions with a zero-wait slave. Required grant order 0,1,0,1, one IDLE cycle between grants, 8 cycles total.
- Write routing: master 1 writes 32'h1234_5678 with wstrb=4'b0011 while master 0 is idle. Required: s_wdata_o=32'h1234_5678 and s_wstrb_o=4'b0011 while s_valid_o=1.
- Timeout: TIMEOUT=4, slave never ready. Required: m_ready_o pulses in XFER cycle 5 with m_rdata_o=32'hFFFF_FFFF, timeout_o pulses in the same cycle, and the other master is granted next. A second run with s_ready_i=1 exactly in cycle 5 gives slave rdata and timeout_o=0.
- Abort: master 0 drops valid in its second XFER cycle. Required: s_valid_o=0 in that cycle, no m_ready_o, and master 1 (if requesting) is granted after one IDLE cycle.
- Reset mid-transfer: assert rst_n_i low during XFER. Required: all outputs go to 0 immediately. After release, master 0 wins the first arbitration even if master 1 was the owner before reset.
